// File: rtl/lgate_if.sv
// Sample-stream bundle for the lgate noise gate: strobed input sample and thresholds in, gated sample out.
// i_bypass exists only when LGATE_BYPASS_EN is defined.
interface lgate_if #(
  parameter int W_TOTAL = 16
);
  logic                      i_ce;
  logic signed [W_TOTAL-1:0] i_data;
  logic signed [W_TOTAL-1:0] i_threshold_pos;
  logic signed [W_TOTAL-1:0] i_threshold_neg;
`ifdef LGATE_BYPASS_EN
  logic                      i_bypass;
`endif
  logic signed [W_TOTAL-1:0] o_data;
  logic                      o_ce;

  modport master (
    output i_ce, i_data, i_threshold_pos, i_threshold_neg,
`ifdef LGATE_BYPASS_EN
    output i_bypass,
`endif
    input  o_data, o_ce
  );

  modport slave (
    input  i_ce, i_data, i_threshold_pos, i_threshold_neg,
`ifdef LGATE_BYPASS_EN
    input  i_bypass,
`endif
    output o_data, o_ce
  );
endinterface

// File: rtl/lgate.sv
// Downward noise gate: five-state envelope FSM with hold timer and linear attack/release gain ramps.
// Optional LGATE_BYPASS_EN adds i_bypass, which passes i_data through while the FSM keeps running.
module lgate #(
  parameter int          W_TOTAL      = 16,
  parameter int          HOLD_CYCLES  = 256,
  parameter logic [15:0] ATTACK_STEP  = 16'h0800,
  parameter logic [15:0] RELEASE_STEP = 16'h0040
) (
  input logic   i_clk,
  input logic   i_reset,
  lgate_if.slave bus
);
  localparam int          CW    = $clog2(HOLD_CYCLES + 1);
  localparam int          PW    = W_TOTAL + 17;
  localparam logic [15:0] UNITY = 16'h8000;

  localparam logic [2:0] CLOSED  = 3'd0;
  localparam logic [2:0] ATTACK  = 3'd1;
  localparam logic [2:0] OPEN    = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  logic [2:0]    state, state_nx;
  logic [15:0]   g, g_nx, g_up, g_dn;
  logic [CW-1:0] cnt, cnt_nx;
  logic          loud;
  logic signed [W_TOTAL-1:0] gated, data_nx;

  // Truncating Q1.15 multiply by an unsigned Q1.15 gain; unity reproduces the input exactly.
  function automatic logic signed [W_TOTAL-1:0] apply_gain(
    input logic signed [W_TOTAL-1:0] x,
    input logic [15:0]               gain
  );
    logic signed [PW-1:0] xa, ga, prod;
    xa   = PW'(x);
    ga   = PW'($signed({1'b0, gain}));
    prod = xa * ga;
    return $signed(prod[W_TOTAL+14:15]);
  endfunction

  function automatic logic [15:0] sat_up(input logic [15:0] gain);
    logic [16:0] s;
    s = {1'b0, gain} + {1'b0, ATTACK_STEP};
    return (s >= {1'b0, UNITY}) ? UNITY : s[15:0];
  endfunction

  function automatic logic [15:0] sat_down(input logic [15:0] gain);
    return (gain <= RELEASE_STEP) ? 16'h0000 : gain - RELEASE_STEP;
  endfunction

  // Inverted thresholds make every sample loud without any special case.
  assign loud  = (bus.i_data > bus.i_threshold_pos) || (bus.i_data < bus.i_threshold_neg);
  assign g_up  = sat_up(g);
  assign g_dn  = sat_down(g);
  assign gated = apply_gain(bus.i_data, g);

`ifdef LGATE_BYPASS_EN
  assign data_nx = bus.i_bypass ? bus.i_data : gated;
`else
  assign data_nx = gated;
`endif

  always_comb begin
    state_nx = state;
    g_nx     = g;
    cnt_nx   = cnt;
    case (state)
      CLOSED: begin
        if (loud) begin
          g_nx     = g_up;
          state_nx = (g_up == UNITY) ? OPEN : ATTACK;
        end
      end
      ATTACK: begin
        g_nx = g_up;
        if (g_up == UNITY) state_nx = OPEN;
      end
      OPEN: begin
        if (!loud) begin
          state_nx = HOLD;
          cnt_nx   = CW'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (loud) begin
          state_nx = OPEN;
        end else if (cnt == '0) begin
          g_nx     = g_dn;
          state_nx = (g_dn == 16'h0000) ? CLOSED : RELEASE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      RELEASE: begin
        if (loud) begin
          g_nx     = g_up;
          state_nx = (g_up == UNITY) ? OPEN : ATTACK;
        end else begin
          g_nx = g_dn;
          if (g_dn == 16'h0000) state_nx = CLOSED;
        end
      end
      default: begin
        state_nx = CLOSED;
        g_nx     = 16'h0000;
        cnt_nx   = '0;
      end
    endcase
  end

  // Output register stage: everything advances only on strobed samples.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= CLOSED;
      g          <= 16'h0000;
      cnt        <= '0;
      bus.o_data <= '0;
      bus.o_ce   <= 1'b0;
    end else begin
      bus.o_ce <= bus.i_ce;
      if (bus.i_ce) begin
        state      <= state_nx;
        g          <= g_nx;
        cnt        <= cnt_nx;
        bus.o_data <= data_nx;
      end
    end
  end
endmodule
